// File: rtl/mac_tx_framer_if.sv
// mac_tx_framer_if
// Groups the user-side byte stream and the on-wire transmit stream of the
// transmit framer.
//   usr_data/usr_valid/usr_sof/usr_eof : user byte stream (DA first)
//   usr_ready                          : byte accepted when usr_valid & usr_ready
//   mac_tx_data/valid/sof/eof          : registered on-wire bytes
// The framer takes the slave modport; the user-side source takes the master.
interface mac_tx_framer_if;
    logic [7:0] usr_data;
    logic       usr_valid;
    logic       usr_sof;
    logic       usr_eof;
    logic       usr_ready;
    logic [7:0] mac_tx_data;
    logic       mac_tx_valid;
    logic       mac_tx_sof;
    logic       mac_tx_eof;

    modport master (
        output usr_data, usr_valid, usr_sof, usr_eof,
        input  usr_ready,
        input  mac_tx_data, mac_tx_valid, mac_tx_sof, mac_tx_eof
    );

    modport slave (
        input  usr_data, usr_valid, usr_sof, usr_eof,
        output usr_ready,
        output mac_tx_data, mac_tx_valid, mac_tx_sof, mac_tx_eof
    );
endinterface

// File: rtl/mac_tx_framer.sv
// mac_tx_framer
// Turns a user byte stream into a complete Ethernet frame on the wire:
// preamble + SFD, user bytes, zero padding up to MIN_LEN, FCS, then an
// inter-frame gap of IFG_LEN idle cycles. Underrun and oversize frames are
// terminated with an inverted FCS and the rest of the user frame is drained.
// Ports:
//   mac_tx_clk   : transmit clock
//   rst          : synchronous, active-high reset
//   bus          : user stream in / wire stream out (slave modport)
//   tx_busy      : framer is not idle
//   tx_err       : one-cycle pulse with the last byte of a bad frame
//   tx_frame_cnt : frames sent with a good FCS (wraps)
//   tx_err_cnt   : frames sent with a corrupted FCS (wraps)
module mac_tx_framer #(
    parameter int MAX_LEN = 1514,
    parameter int MIN_LEN = 60,
    parameter int PAD_EN  = 1,
    parameter int IFG_LEN = 12
) (
    input  logic                  mac_tx_clk,
    input  logic                  rst,
    mac_tx_framer_if.slave        bus,
    output logic                  tx_busy,
    output logic                  tx_err,
    output logic [15:0]           tx_frame_cnt,
    output logic [15:0]           tx_err_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_PREAMBLE, ST_SFD, ST_DATA, ST_PAD, ST_FCS, ST_DRAIN, ST_IFG
    } state_t;

    // The byte counter is 11 bits wide, so MAX_LEN must stay below 2048.
    localparam logic [10:0] MAX_CNT  = 11'(MAX_LEN);
    localparam logic [10:0] MIN_CNT  = 11'(MIN_LEN);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_LEN - 1);

    state_t      state, state_nxt;
    logic [7:0]  phase, phase_nxt;
    logic [10:0] byte_cnt, byte_cnt_nxt, cnt_inc;
    logic [31:0] crc, crc_nxt, fcs_word;
    logic        bad_frame, bad_frame_nxt;
    logic        eof_seen, eof_seen_nxt;
    logic [7:0]  data_nxt;
    logic        valid_nxt, sof_nxt, eof_nxt, err_nxt;
    logic [15:0] frame_cnt_nxt, err_cnt_nxt;

    // Reflected CRC-32 (0xEDB88320), one byte per call, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign tx_busy  = (state != ST_IDLE);
    assign cnt_inc  = byte_cnt + 11'd1;
    // A bad frame sends the bitwise inverse of the correct FCS (~crc), i.e. crc itself.
    assign fcs_word = bad_frame ? crc : ~crc;

    // Every wire output is computed here one cycle ahead and registered below,
    // so the byte accepted in cycle T is on the wire in cycle T+1. The first
    // preamble byte is launched from IDLE itself so that the wire shows exactly
    // IFG_LEN idle cycles between frames.
    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase;
        byte_cnt_nxt  = byte_cnt;
        crc_nxt       = crc;
        bad_frame_nxt = bad_frame;
        eof_seen_nxt  = eof_seen;
        data_nxt      = 8'h00;
        valid_nxt     = 1'b0;
        sof_nxt       = 1'b0;
        eof_nxt       = 1'b0;
        err_nxt       = 1'b0;
        frame_cnt_nxt = tx_frame_cnt;
        err_cnt_nxt   = tx_err_cnt;
        bus.usr_ready = 1'b0;

        case (state)
            ST_IDLE: begin
                crc_nxt       = 32'hFFFFFFFF;
                byte_cnt_nxt  = '0;
                bad_frame_nxt = 1'b0;
                eof_seen_nxt  = 1'b0;
                phase_nxt     = '0;
                if (bus.usr_valid) begin
                    if (bus.usr_sof) begin
                        // The sof byte stays on the bus until DATA consumes it.
                        state_nxt = ST_PREAMBLE;
                        phase_nxt = 8'd1;
                        data_nxt  = 8'h55;
                        valid_nxt = 1'b1;
                        sof_nxt   = 1'b1;
                    end else begin
                        // Stray bytes outside a frame are swallowed.
                        bus.usr_ready = 1'b1;
                    end
                end
            end

            ST_PREAMBLE: begin
                data_nxt  = 8'h55;
                valid_nxt = 1'b1;
                if (phase == 8'd6) begin
                    state_nxt = ST_SFD;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase + 8'd1;
                end
            end

            ST_SFD: begin
                data_nxt  = 8'hD5;
                valid_nxt = 1'b1;
                state_nxt = ST_DATA;
            end

            ST_DATA: begin
                bus.usr_ready = 1'b1;
                phase_nxt     = '0;
                if (bus.usr_valid) begin
                    data_nxt     = bus.usr_data;
                    valid_nxt    = 1'b1;
                    crc_nxt      = crc_byte(crc, bus.usr_data);
                    byte_cnt_nxt = cnt_inc;
                    if (bus.usr_eof) begin
                        eof_seen_nxt = 1'b1;
                        state_nxt    = ((PAD_EN != 0) && (cnt_inc < MIN_CNT)) ? ST_PAD : ST_FCS;
                    end else if (cnt_inc == MAX_CNT) begin
                        bad_frame_nxt = 1'b1;
                        state_nxt     = ST_FCS;
                    end
                end else begin
                    // Underrun: there is no data byte to send this cycle, so the
                    // first (inverted) FCS byte goes out now to keep the wire
                    // continuous, and FCS continues with the second byte.
                    bad_frame_nxt = 1'b1;
                    data_nxt      = crc[7:0];
                    valid_nxt     = 1'b1;
                    phase_nxt     = 8'd1;
                    state_nxt     = ST_FCS;
                end
            end

            ST_PAD: begin
                data_nxt     = 8'h00;
                valid_nxt    = 1'b1;
                crc_nxt      = crc_byte(crc, 8'h00);
                byte_cnt_nxt = cnt_inc;
                if (cnt_inc >= MIN_CNT) begin
                    state_nxt = ST_FCS;
                    phase_nxt = '0;
                end
            end

            ST_FCS: begin
                data_nxt  = fcs_word[{phase[1:0], 3'b000} +: 8];
                valid_nxt = 1'b1;
                if (phase[1:0] == 2'd3) begin
                    eof_nxt   = 1'b1;
                    phase_nxt = '0;
                    if (bad_frame) begin
                        err_nxt     = 1'b1;
                        err_cnt_nxt = tx_err_cnt + 16'd1;
                        state_nxt   = eof_seen ? ST_IFG : ST_DRAIN;
                    end else begin
                        frame_cnt_nxt = tx_frame_cnt + 16'd1;
                        state_nxt     = ST_IFG;
                    end
                end else begin
                    phase_nxt = phase + 8'd1;
                end
            end

            ST_DRAIN: begin
                bus.usr_ready = 1'b1;
                if (bus.usr_valid && bus.usr_eof) begin
                    state_nxt = ST_IFG;
                    phase_nxt = '0;
                end
            end

            ST_IFG: begin
                if (phase == IFG_LAST) begin
                    state_nxt = ST_IDLE;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase + 8'd1;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge mac_tx_clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            phase            <= '0;
            byte_cnt         <= '0;
            crc              <= 32'hFFFFFFFF;
            bad_frame        <= 1'b0;
            eof_seen         <= 1'b0;
            bus.mac_tx_data  <= 8'h00;
            bus.mac_tx_valid <= 1'b0;
            bus.mac_tx_sof   <= 1'b0;
            bus.mac_tx_eof   <= 1'b0;
            tx_err           <= 1'b0;
            tx_frame_cnt     <= '0;
            tx_err_cnt       <= '0;
        end else begin
            state            <= state_nxt;
            phase            <= phase_nxt;
            byte_cnt         <= byte_cnt_nxt;
            crc              <= crc_nxt;
            bad_frame        <= bad_frame_nxt;
            eof_seen         <= eof_seen_nxt;
            bus.mac_tx_data  <= data_nxt;
            bus.mac_tx_valid <= valid_nxt;
            bus.mac_tx_sof   <= sof_nxt;
            bus.mac_tx_eof   <= eof_nxt;
            tx_err           <= err_nxt;
            tx_frame_cnt     <= frame_cnt_nxt;
            tx_err_cnt       <= err_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mac_tx_framer.sv
// tb_mac_tx_framer
// Drives two framers: a main one (MAX_LEN=64, padding on) checked every cycle
// against a frame-level model, and a no-padding one checked against the
// well-known "123456789" frame byte by byte.
module tb_mac_tx_framer;

    localparam int MAXL = 64;
    localparam int MINL = 60;
    localparam int IFGL = 12;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eof;
        logic       bad;
    } wire_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  drv_data  = 8'h00;
    logic        drv_valid = 1'b0;
    logic        drv_sof   = 1'b0;
    logic        drv_eof   = 1'b0;
    logic        drv_sel   = 1'b0;

    logic        busy_m, err_m, busy_n, err_n;
    logic [15:0] fcnt_m, ecnt_m, fcnt_n, ecnt_n;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;

    wire_t       exp_q[$];
    int          model_good = 0;
    int          model_bad = 0;
    bit          mid_frame = 0;
    bit          b2b_mode = 0;
    bit          prev_eof_valid = 0;
    int          prev_eof_cyc = 0;
    int          cur_len = 0;
    int          len_q[$];
    int          sof_q[$];
    logic [9:0]  np_cap[$];
    wire_t       cmp_ent;

    logic [7:0]  frame_buf [0:127];
    logic [7:0]  msg_buf   [0:127];

    always #4 clk = ~clk;

    mac_tx_framer_if bus_m ();
    mac_tx_framer_if bus_n ();

    assign bus_m.usr_data  = drv_data;
    assign bus_m.usr_sof   = drv_sof;
    assign bus_m.usr_eof   = drv_eof;
    assign bus_m.usr_valid = drv_valid & ~drv_sel;
    assign bus_n.usr_data  = drv_data;
    assign bus_n.usr_sof   = drv_sof;
    assign bus_n.usr_eof   = drv_eof;
    assign bus_n.usr_valid = drv_valid & drv_sel;

    mac_tx_framer #(.MAX_LEN(MAXL), .MIN_LEN(MINL), .PAD_EN(1), .IFG_LEN(IFGL)) dut_main (
        .mac_tx_clk   (clk),
        .rst          (rst),
        .bus          (bus_m.slave),
        .tx_busy      (busy_m),
        .tx_err       (err_m),
        .tx_frame_cnt (fcnt_m),
        .tx_err_cnt   (ecnt_m)
    );

    mac_tx_framer #(.MAX_LEN(1514), .MIN_LEN(60), .PAD_EN(0), .IFG_LEN(12)) dut_np (
        .mac_tx_clk   (clk),
        .rst          (rst),
        .bus          (bus_n.slave),
        .tx_busy      (busy_n),
        .tx_err       (err_n),
        .tx_frame_cnt (fcnt_n),
        .tx_err_cnt   (ecnt_n)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic reportTimeout(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // Standard CRC-32 computed MSB-first with the normal polynomial on
    // bit-reversed input, then reflected and complemented.
    function automatic logic [31:0] crc32_ref(input int len);
        logic [31:0] r, o;
        logic        fb;
        r = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = r[31] ^ msg_buf[i][b];
                r  = {r[30:0], 1'b0};
                if (fb) r = r ^ 32'h04C11DB7;
            end
        end
        for (int k = 0; k < 32; k++) o[k] = r[31 - k];
        return ~o;
    endfunction

    // Frame-level model of what the main framer must put on the wire.
    task automatic pushExpected(input int n, input int u);
        int          cnt, tot;
        bit          bad;
        logic [31:0] fcs;
        wire_t       e;
        if (u > 0 && u < n && u < MAXL) begin cnt = u; bad = 1; end
        else if (n > MAXL)              begin cnt = MAXL; bad = 1; end
        else                            begin cnt = n; bad = 0; end
        tot = (!bad && cnt < MINL) ? MINL : cnt;
        for (int i = 0; i < tot; i++) msg_buf[i] = (i < cnt) ? frame_buf[i] : 8'h00;
        fcs = crc32_ref(tot);
        if (bad) fcs = ~fcs;
        for (int i = 0; i < 7; i++) begin
            e = '{d: 8'h55, sof: (i == 0), eof: 1'b0, bad: 1'b0};
            exp_q.push_back(e);
        end
        e = '{d: 8'hD5, sof: 1'b0, eof: 1'b0, bad: 1'b0};
        exp_q.push_back(e);
        for (int i = 0; i < tot; i++) begin
            e = '{d: msg_buf[i], sof: 1'b0, eof: 1'b0, bad: 1'b0};
            exp_q.push_back(e);
        end
        for (int k = 0; k < 4; k++) begin
            e = '{d: fcs[8*k +: 8], sof: 1'b0, eof: (k == 3), bad: bad};
            exp_q.push_back(e);
        end
    endtask

    // Holds the current byte until the selected framer's usr_ready is seen.
    task automatic handshake(input string name);
        bit ok = 0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (drv_sel ? bus_n.usr_ready : bus_m.usr_ready) ok = 1;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            reportTimeout(name);
        end
    endtask

    // n bytes from frame_buf; u>0 drops usr_valid for one cycle after u bytes;
    // r>=0 pulses rst after r bytes and abandons the frame.
    task automatic applyStimulus(input int n, input int u, input bit sel, input bit stray, input int r);
        drv_sel = sel;
        if (!sel) pushExpected(n, u);
        if (stray) begin
            drv_valid = 1; drv_sof = 0; drv_eof = 0; drv_data = 8'($urandom);
            handshake("stray_handshake");
        end
        for (int i = 0; i < n; i++) begin
            if (u > 0 && i == u) begin
                drv_valid = 0;
                @(posedge clk);
                #1;
            end
            if (i == r) begin
                drv_valid = 0;
                rst = 1;
                @(posedge clk);
                #1;
                rst = 0;
                drv_sof = 0;
                drv_eof = 0;
                return;
            end
            drv_valid = 1;
            drv_sof   = (i == 0);
            drv_eof   = (i == n - 1);
            drv_data  = frame_buf[i];
            handshake("byte_handshake");
        end
        drv_valid = 0;
        drv_sof   = 0;
        drv_eof   = 0;
    endtask

    task automatic waitIdle();
        bit done = 0;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1;
        end
        if (!done) reportTimeout("wire_drain");
        repeat (2) @(negedge clk);
    endtask

    // Every-cycle comparison of the main framer against the model queue.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            model_good     = 0;
            model_bad      = 0;
            mid_frame      = 0;
            prev_eof_valid = 0;
        end else begin
            if (bus_m.mac_tx_valid) begin
                checkOutput("busy_in_frame", busy_m, 1);
                if (exp_q.size() == 0) begin
                    reportTimeout("unexpected_wire_byte");
                end else begin
                    cmp_ent = exp_q.pop_front();
                    checkOutput("wire_data", bus_m.mac_tx_data, cmp_ent.d);
                    checkOutput("wire_sof", bus_m.mac_tx_sof, cmp_ent.sof);
                    checkOutput("wire_eof", bus_m.mac_tx_eof, cmp_ent.eof);
                    checkOutput("tx_err", err_m, cmp_ent.eof & cmp_ent.bad);
                    if (cmp_ent.sof) begin
                        if (prev_eof_valid) begin
                            if (b2b_mode) checkOutput("ifg_exact", cyc - prev_eof_cyc - 1, IFGL);
                            else          checkOutput("ifg_min", (cyc - prev_eof_cyc - 1) >= IFGL, 1);
                        end
                        sof_q.push_back(cyc);
                        mid_frame = 1;
                        cur_len   = 0;
                    end
                    cur_len++;
                    if (cmp_ent.eof) begin
                        if (cmp_ent.bad) model_bad++;
                        else             model_good++;
                        len_q.push_back(cur_len);
                        mid_frame      = 0;
                        prev_eof_cyc   = cyc;
                        prev_eof_valid = 1;
                    end
                end
            end else begin
                checkOutput("wire_gap", mid_frame, 0);
                checkOutput("tx_err_idle", err_m, 0);
            end
            checkOutput("tx_frame_cnt", fcnt_m, 32'(model_good & 16'hFFFF));
            checkOutput("tx_err_cnt", ecnt_m, 32'(model_bad & 16'hFFFF));
        end
    end

    always @(negedge clk) begin
        if (!rst && bus_n.mac_tx_valid)
            np_cap.push_back({bus_n.mac_tx_sof, bus_n.mac_tx_eof, bus_n.mac_tx_data});
    end

    initial begin
        logic [7:0] np_exp [0:20];
        int         n, u;
        bit         st;

        $display("[TB] start");
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checkOutput("reset_valid", bus_m.mac_tx_valid, 0);
        checkOutput("reset_busy", busy_m, 0);
        checkOutput("reset_frame_cnt", fcnt_m, 0);
        checkOutput("reset_err_cnt", ecnt_m, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) msg_buf[i] = 8'(8'h31 + i);
        checkOutput("model_crc_123456789", crc32_ref(9), 32'hCBF43926);

        // No-padding framer: "123456789" must come out verbatim with FCS 26 39 F4 CB.
        for (int i = 0; i < 9; i++) frame_buf[i] = 8'(8'h31 + i);
        for (int i = 0; i < 7; i++) np_exp[i] = 8'h55;
        np_exp[7] = 8'hD5;
        for (int i = 0; i < 9; i++) np_exp[8 + i] = 8'(8'h31 + i);
        np_exp[17] = 8'h26; np_exp[18] = 8'h39; np_exp[19] = 8'hF4; np_exp[20] = 8'hCB;
        applyStimulus(9, -1, 1, 0, -1);
        begin
            bit got = 0;
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clk);
                if (np_cap.size() >= 21) got = 1;
            end
            if (!got) reportTimeout("nopad_frame");
        end
        checkOutput("nopad_len", np_cap.size(), 21);
        for (int i = 0; i < 21 && i < np_cap.size(); i++) begin
            checkOutput("nopad_byte", np_cap[i][7:0], np_exp[i]);
            checkOutput("nopad_sof", np_cap[i][9], (i == 0));
            checkOutput("nopad_eof", np_cap[i][8], (i == 20));
        end
        @(negedge clk);
        checkOutput("nopad_frame_cnt", fcnt_n, 1);
        @(posedge clk);
        #1;

        // Short header padded to 60, then three 60-byte frames back to back.
        sof_q.delete();
        len_q.delete();
        b2b_mode = 1;
        for (int i = 0; i < 14; i++) frame_buf[i] = 8'($urandom);
        applyStimulus(14, -1, 0, 0, -1);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 60; i++) frame_buf[i] = 8'($urandom);
            applyStimulus(60, -1, 0, 0, -1);
        end
        waitIdle();
        b2b_mode = 0;
        checkOutput("padded_valid_cycles", (len_q.size() > 0) ? len_q[0] : 0, 72);
        checkOutput("b2b_sof_count", sof_q.size(), 4);
        for (int k = 1; k < sof_q.size(); k++)
            checkOutput("b2b_period", sof_q[k] - sof_q[k - 1], 84);
        checkOutput("b2b_frame_cnt", fcnt_m, 4);

        // Underrun after 20 bytes; the rest of the frame is drained.
        @(posedge clk);
        #1;
        for (int i = 0; i < 30; i++) frame_buf[i] = 8'($urandom);
        applyStimulus(30, 20, 0, 0, -1);
        waitIdle();
        checkOutput("underrun_err_cnt", ecnt_m, 1);

        // Oversize 70 bytes, then exactly MAXL bytes with eof.
        @(posedge clk);
        #1;
        for (int i = 0; i < 70; i++) frame_buf[i] = 8'($urandom);
        applyStimulus(70, -1, 0, 0, -1);
        for (int i = 0; i < MAXL; i++) frame_buf[i] = 8'($urandom);
        applyStimulus(MAXL, -1, 0, 0, -1);
        waitIdle();
        checkOutput("oversize_err_cnt", ecnt_m, 2);
        checkOutput("maxlen_frame_cnt", fcnt_m, 5);

        // Reset in the middle of DATA, then a clean frame.
        @(posedge clk);
        #1;
        for (int i = 0; i < 40; i++) frame_buf[i] = 8'($urandom);
        applyStimulus(40, -1, 0, 0, 10);
        @(negedge clk);
        checkOutput("midreset_valid", bus_m.mac_tx_valid, 0);
        checkOutput("midreset_frame_cnt", fcnt_m, 0);
        checkOutput("midreset_err_cnt", ecnt_m, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 50; i++) frame_buf[i] = 8'($urandom);
        applyStimulus(50, -1, 0, 0, -1);
        waitIdle();
        checkOutput("after_reset_frame_cnt", fcnt_m, 1);

        // Random frames: lengths around MIN/MAX, occasional underrun and stray bytes.
        @(posedge clk);
        #1;
        for (int f = 0; f < 25; f++) begin
            n  = $urandom_range(1, 70);
            u  = -1;
            st = ($urandom_range(0, 3) == 0);
            if (n > 2 && $urandom_range(0, 4) == 0) u = $urandom_range(1, (n < MAXL) ? n - 1 : MAXL - 1);
            for (int i = 0; i < n; i++) frame_buf[i] = 8'($urandom);
            applyStimulus(n, u, 0, st, -1);
        end
        waitIdle();
        checkOutput("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mac_tx_framer.md
Name: mac_tx_framer

Overview:
- Transmit-side framer that turns a user byte stream into a complete on-wire Ethernet frame for the mac_rgmii transmit port (mac_tx_data/valid/sof/eof), clocked by mac_gtx_clk.
- Adds preamble and SFD, pads short frames, appends the IEEE 802.3 FCS and enforces the inter-frame gap.
- Frames it produces must be reported fr_good by the receive path when looped back.
- Underrun and oversize frames are sent with a corrupted FCS so the far end rejects them.

Parameters:
- MAX_LEN, 1514: maximum user bytes per frame (DA through payload, excluding FCS).
- MIN_LEN, 60: minimum bytes before FCS; shorter frames are padded with 0x00.
- PAD_EN, 1: 1 enables padding to MIN_LEN; 0 disables it (test only).
- IFG_LEN, 12: idle cycles (mac_tx_valid=0) after each frame's last FCS byte.

Ports:
- mac_tx_clk in 1: 125 MHz transmit clock.
- rst in 1: synchronous, active-high reset.
- usr_data in 8: user byte (DA first).
- usr_valid in 1: usr_data is valid.
- usr_sof in 1: first byte of a frame.
- usr_eof in 1: last byte of a frame.
- usr_ready out 1: byte accepted when usr_valid & usr_ready.
- mac_tx_data out 8: on-wire byte.
- mac_tx_valid out 1: mac_tx_data is valid.
- mac_tx_sof out 1: first preamble byte.
- mac_tx_eof out 1: last FCS byte.
- tx_busy out 1: state is not IDLE.
- tx_err out 1: one-cycle pulse when an underrun or oversize frame is terminated.
- tx_frame_cnt out 16: frames sent with good FCS; wraps at 0xFFFF→0.
- tx_err_cnt out 16: frames sent with corrupted FCS; wraps.

Behaviour:
- Reset, on the same edge: every mac_tx_* output, tx_busy, tx_err, both counters and the CRC go to 0 (CRC register to 0xFFFFFFFF); state → IDLE.
  - Reset mid-frame truncates the frame with no eof.
- All mac_tx_* outputs are registered. The byte accepted in cycle T appears on mac_tx_data in cycle T+1.
- There is no output backpressure: one byte per cycle while a frame is in flight.
- usr_ready is combinational from state and inputs:
  - 1 in DATA and DRAIN.
  - 1 in IDLE only when usr_valid & ~usr_sof; stray bytes are discarded and not counted.
  - 0 otherwise.
- States:
  - IDLE: usr_valid & usr_sof → PREAMBLE. The sof byte is not consumed in IDLE.
  - PREAMBLE: 7 cycles of 0x55; the first cycle carries mac_tx_sof=1.
  - SFD: 1 cycle of 0xD5 → DATA.
  - DATA: each accepted byte is output, fed to the CRC and increments the byte count (11 bits).
    - usr_sof inside DATA is ignored; the byte is treated as data.
    - Accepted usr_eof: count < MIN_LEN and PAD_EN → PAD; otherwise → FCS (good).
    - usr_valid=0 (underrun) → FCS (bad), then DRAIN.
    - count reaches MAX_LEN without eof → FCS (bad), then DRAIN.
    - eof on exactly byte MAX_LEN is a good frame.
  - PAD: output 0x00, fed to the CRC, until count = MIN_LEN → FCS.
  - FCS: 4 cycles sending ~crc LSB byte first; mac_tx_eof=1 on the 4th byte.
    - Bad frames send the bitwise inverse of the correct FCS.
    - On the 4th byte: increment the matching counter; pulse tx_err for bad frames.
    - Next state: DRAIN if bad, else IFG.
  - DRAIN: usr_ready=1; discard bytes until usr_eof is accepted, then → IFG.
    - If eof was already consumed before entering, go straight to IFG.
  - IFG: IFG_LEN cycles with mac_tx_valid=0 and usr_ready=0 → IDLE.
- CRC: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, byte-wise update over DA through the last pad byte. Preamble and SFD are excluded.
- Minimum wire occupancy per frame: 8 + max(N, MIN_LEN) + 4 + IFG_LEN cycles.

Test Plan:
- PAD_EN=0; send ASCII "123456789" (9 bytes) → wire shows 7×0x55, 0xD5, the 9 bytes, then FCS 0x26 0x39 0xF4 0xCB; eof on 0xCB; tx_frame_cnt=1.
- PAD_EN=1; send a 14-byte header → 46 bytes of 0x00 follow, then FCS matching a reference CRC over 60 bytes; total 72 valid cycles; next sof is sent after exactly 12 idle cycles.
- Drop usr_valid for 1 cycle after 20 bytes → next 4 bytes are the inverted CRC of those 20 bytes; tx_err pulses; tx_err_cnt=1; remaining input through eof is discarded.
- MAX_LEN=64; send 70 bytes → 64 bytes, then bad FCS, then 6 bytes drained; tx_err_cnt increments. Send exactly 64 bytes with eof → good FCS.
- Assert rst during DATA → next cycle mac_tx_valid=0 and counters=0; a following frame transmits correctly.
- Back-to-back 60-byte frames with usr_valid held high → 84-cycle period (72 valid + 12 idle); tx_frame_cnt counts all frames.
